// File: rtl/fully_pipelined_subtractor.sv
// Ripple-borrow subtractor: d = a - b - bin, one difference bit resolved per stage, global stall.
// Define FULLY_PIPELINED_SUBTRACTOR_OVF_EN to add the registered signed-overflow output ovf.

module fully_pipelined_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] d,
   output logic             bout,
   output logic             out_valid,
   input  logic             out_ready
`ifdef FULLY_PIPELINED_SUBTRACTOR_OVF_EN
   ,
   output logic             ovf
`endif
);

   // The b-lane shrinks by one bit per stage, so it is kept as one triangular vector.
   localparam int BL = (WIDTH * (WIDTH - 1)) / 2;

   logic             en;
   logic [WIDTH-1:0] a_q [WIDTH];
   logic [WIDTH-1:0] a_d [WIDTH];
   logic [WIDTH-1:0] brw_q;
   logic [WIDTH-1:0] brw_d;
   logic [WIDTH-1:0] vld_q;
   logic [WIDTH-1:0] vld_d;
   logic [BL-1:0]    b_q;
   logic [BL-1:0]    b_d;

   assign en       = out_ready | ~vld_q[WIDTH-1];
   assign in_ready = en;

   for (genvar s = 0; s < WIDTH; s++) begin : g_stg
      // Stage s stores the still-unused b bits s+1..WIDTH-1 starting at offset BS.
      localparam int BS = s * (WIDTH - 1) - (s * (s - 1)) / 2;
      localparam logic [WIDTH-1:0] MSK = WIDTH'(1) << s;

      logic [WIDTH-1:0] cur_a;
      logic             cur_b;
      logic             cur_c;
      logic             cur_v;
      logic             t;
      logic             dif;

      if (s == 0) begin : g_head
         assign cur_a = a;
         assign cur_b = b[0];
         assign cur_c = bin;
         assign cur_v = in_valid;
         for (genvar j = 1; j < WIDTH; j++) begin : g_b
            assign b_d[BS + j - 1] = b[j];
         end
      end else begin : g_body
         localparam int BP = (s - 1) * (WIDTH - 1) - ((s - 1) * (s - 2)) / 2;
         assign cur_a = a_q[s-1];
         assign cur_b = b_q[BP];
         assign cur_c = brw_q[s-1];
         assign cur_v = vld_q[s-1];
         for (genvar j = s + 1; j < WIDTH; j++) begin : g_b
            assign b_d[BS + j - s - 1] = b_q[BP + j - s];
         end
      end

      assign t        = cur_a[s] ^ cur_b;
      assign dif      = t ^ cur_c;
      assign a_d[s]   = (cur_a & ~MSK) | ({WIDTH{dif}} & MSK);
      assign brw_d[s] = (~cur_a[s] & cur_b) | (~t & cur_c);
      assign vld_d[s] = cur_v;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < WIDTH; s++) begin
            a_q[s] <= '0;
         end
         b_q   <= '0;
         brw_q <= '0;
         vld_q <= '0;
      end else if (en) begin
         for (int s = 0; s < WIDTH; s++) begin
            a_q[s] <= a_d[s];
         end
         b_q   <= b_d;
         brw_q <= brw_d;
         vld_q <= vld_d;
      end
   end

   assign d         = a_q[WIDTH-1];
   assign bout      = brw_q[WIDTH-1];
   assign out_valid = vld_q[WIDTH-1];

`ifdef FULLY_PIPELINED_SUBTRACTOR_OVF_EN
   // The original a/b MSBs ride the lanes untouched until the last stage consumes them.
   logic ovf_d;
   logic ovf_q;

   assign ovf_d = (a_q[WIDTH-2][WIDTH-1] ^ b_q[BL-1]) &
                  (a_q[WIDTH-2][WIDTH-1] ^ a_d[WIDTH-1][WIDTH-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (en) begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

endmodule
